// File: rtl/embedded_adc_scan_if.sv
// Bus bundle for embedded_adc_scan.
// Groups the LTC2308 serial pins and the channel-tagged output stream.
//   adc_convst / adc_sck / adc_sdi : driven by the controller (master)
//   adc_sdo                        : driven by the converter
//   data_stream_adc                : {20'b0, 12-bit result}
//   data_stream_ch                 : channel of data_stream_adc
//   data_stream_valid_adc          : one-cycle strobe, data/ch hold until next strobe
interface embedded_adc_scan_if;
    logic        adc_convst;
    logic        adc_sck;
    logic        adc_sdi;
    logic        adc_sdo;
    logic [31:0] data_stream_adc;
    logic [2:0]  data_stream_ch;
    logic        data_stream_valid_adc;

    modport master (
        output adc_convst, adc_sck, adc_sdi,
        input  adc_sdo,
        output data_stream_adc, data_stream_ch, data_stream_valid_adc
    );

    modport slave (
        input  adc_convst, adc_sck, adc_sdi,
        output adc_sdo,
        input  data_stream_adc, data_stream_ch, data_stream_valid_adc
    );
endinterface

// File: rtl/embedded_adc_scan.sv
// Multi-channel LTC2308 scan controller.
// A sample-rate timer produces ticks; each tick (when idle) converts either
// sel_ch or every channel set in ch_mask, one frame per channel. The ADC uses
// the config word sent during frame k for the conversion of frame k+1, so each
// frame sends the config of the *next* list entry and tags its own result with
// the channel configured one frame earlier.
// Ports:
//   clk, reset        : system clock, asynchronous active-high reset
//   enable            : run; low lets the current frame finish then idles
//   periodo_muestreo  : tick period in clk cycles (0/1 = every cycle)
//   scan_mode         : 0 = single channel sel_ch, 1 = scan ch_mask
//   sel_ch, ch_mask   : channel selection, latched at scan start
//   overrun           : sticky, a tick arrived while a scan was busy
//   bus (master)      : ADC pins and output stream
module embedded_adc_scan #(
    parameter int NUM_CH      = 8,
    parameter int SCK_DIV     = 2,
    parameter int CONV_CYCLES = 80,
    parameter int GAP_CYCLES  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [31:0]       periodo_muestreo,
    input  logic              scan_mode,
    input  logic [2:0]        sel_ch,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              overrun,
    embedded_adc_scan_if.master bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CONV  = 3'd1;
    localparam logic [2:0] S_LEAD  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    // Lowest set channel strictly above 'above' (pass -1 for the first one).
    function automatic logic [2:0] lowest_ch(input logic [NUM_CH-1:0] m, input int above);
        logic [2:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (m[i] && i > above) r = 3'(i);
        return r;
    endfunction

    function automatic logic any_above(input logic [NUM_CH-1:0] m, input int above);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            if (m[i] && i > above) r = 1'b1;
        return r;
    endfunction

    // LTC2308 config: S/D, O/S, S1, S0, UNI, SLP
    function automatic logic [5:0] cfg_word(input logic [2:0] ch);
        return {1'b1, ch[0], ch[2], ch[1], 2'b10};
    endfunction

    logic [31:0]       tcnt;
    logic              tick;
    logic [2:0]        state;
    logic [31:0]       cnt;
    logic [3:0]        bit_cnt;
    logic [5:0]        cfg_sr;
    logic [11:0]       sr;
    logic [2:0]        cur_ch;
    logic [2:0]        tag;
    logic              l_mode;
    logic [2:0]        l_sel;
    logic [NUM_CH-1:0] l_mask;
    logic              primed;
    logic              abort;
    logic [2:0]        first_ch;
    logic              list_ok;
    logic              has_next;
    logic [2:0]        nxt_ch;

    assign tick = enable && ((periodo_muestreo <= 32'd1) ||
                             (tcnt == periodo_muestreo - 32'd1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tcnt <= '0;
        else if (!enable || tick)
            tcnt <= '0;
        else
            tcnt <= tcnt + 32'd1;
    end

    always_comb begin
        first_ch = scan_mode ? lowest_ch(ch_mask, -1) : sel_ch;
        list_ok  = !scan_mode || (ch_mask != '0);
        has_next = l_mode && any_above(l_mask, int'(cur_ch));
        // After the last entry the config wraps to list[0], priming the next scan.
        if (!l_mode)
            nxt_ch = l_sel;
        else if (has_next)
            nxt_ch = lowest_ch(l_mask, int'(cur_ch));
        else
            nxt_ch = lowest_ch(l_mask, -1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                     <= S_IDLE;
            cnt                       <= '0;
            bit_cnt                   <= '0;
            cfg_sr                    <= '0;
            sr                        <= '0;
            cur_ch                    <= '0;
            tag                       <= '0;
            l_mode                    <= 1'b0;
            l_sel                     <= '0;
            l_mask                    <= '0;
            primed                    <= 1'b0;
            abort                     <= 1'b0;
            overrun                   <= 1'b0;
            bus.adc_convst            <= 1'b0;
            bus.adc_sck               <= 1'b0;
            bus.adc_sdi               <= 1'b0;
            bus.data_stream_adc       <= '0;
            bus.data_stream_ch        <= '0;
            bus.data_stream_valid_adc <= 1'b0;
        end else begin
            bus.data_stream_valid_adc <= 1'b0;
            if (tick && state != S_IDLE) overrun <= 1'b1;
            if (!enable) overrun <= 1'b0;
            // Remember an enable drop anywhere inside a scan, even if it comes back.
            if (!enable && state != S_IDLE) abort <= 1'b1;

            case (state)
                S_IDLE: begin
                    abort <= 1'b0;
                    if (!enable) primed <= 1'b0;
                    if (tick && list_ok) begin
                        l_mode         <= scan_mode;
                        l_sel          <= sel_ch;
                        l_mask         <= ch_mask;
                        cur_ch         <= first_ch;
                        // Keep priming only if the ADC already holds list[0]'s config.
                        primed         <= primed && (tag == first_ch);
                        cnt            <= '0;
                        bus.adc_convst <= 1'b1;
                        state          <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (cnt == 32'(CONV_CYCLES - 1)) begin
                        bus.adc_convst <= 1'b0;
                        cfg_sr         <= cfg_word(nxt_ch);
                        bus.adc_sdi    <= cfg_word(nxt_ch)[5];
                        cnt            <= '0;
                        state          <= S_LEAD;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_LEAD: begin
                    if (cnt == 32'(SCK_DIV - 1)) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= S_SHIFT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_SHIFT: begin
                    if (cnt == 32'(SCK_DIV - 1)) begin
                        cnt <= '0;
                        if (!bus.adc_sck) begin
                            bus.adc_sck <= 1'b1;
                            sr          <= {sr[10:0], bus.adc_sdo};
                        end else begin
                            // Falling edge: next config bit, zeros after the sixth.
                            bus.adc_sck <= 1'b0;
                            bus.adc_sdi <= cfg_sr[4];
                            cfg_sr      <= {cfg_sr[4:0], 1'b0};
                            if (bit_cnt == 4'd11)
                                state <= S_DONE;
                            else
                                bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_DONE: begin
                    if (primed && enable && !abort) begin
                        bus.data_stream_adc       <= {20'b0, sr};
                        bus.data_stream_ch        <= tag;
                        bus.data_stream_valid_adc <= 1'b1;
                    end
                    tag <= nxt_ch;
                    cnt <= '0;
                    if (!enable || abort) begin
                        primed <= 1'b0;
                        abort  <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        primed <= 1'b1;
                        state  <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (cnt + 32'd1 >= 32'(GAP_CYCLES)) begin
                        cnt <= '0;
                        if (!enable || abort) begin
                            primed <= 1'b0;
                            abort  <= 1'b0;
                            state  <= S_IDLE;
                        end else if (has_next) begin
                            cur_ch         <= nxt_ch;
                            bus.adc_convst <= 1'b1;
                            state          <= S_CONV;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_embedded_adc_scan.sv
// Bench for embedded_adc_scan: LTC2308 device model on the serial pins,
// a tick-level expectation model of the output stream, and directed steps.
`timescale 1ns/1ps
module tb_embedded_adc_scan;

    localparam int MARGIN = 1150;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] periodo_muestreo = 32'd2000;
    logic        scan_mode = 1'b0;
    logic [2:0]  sel_ch = 3'd0;
    logic [7:0]  ch_mask = 8'd0;
    logic        overrun;

    embedded_adc_scan_if bus();

    embedded_adc_scan #(
        .NUM_CH(8), .SCK_DIV(2), .CONV_CYCLES(80), .GAP_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .periodo_muestreo(periodo_muestreo),
        .scan_mode(scan_mode),
        .sel_ch(sel_ch),
        .ch_mask(ch_mask),
        .overrun(overrun),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- LTC2308 device model ----------------
    int          value_mode = 0;
    logic [11:0] rand_tab [8];
    logic [5:0]  cfg_in = '0;
    logic [5:0]  cfg_cur = '0;
    logic [5:0]  last_cfg = '0;
    logic [11:0] shreg = '0;
    int          sdi_bits = 0;
    int          frame_sck = 0;
    int          convst_cnt = 0;

    function automatic logic [11:0] adc_val(input logic [2:0] ch);
        case (value_mode)
            0:       return 12'hA5C;
            1:       return 12'h100 + {9'b0, ch};
            default: return rand_tab[ch];
        endcase
    endfunction

    always @(posedge bus.adc_convst or posedge bus.adc_sck or negedge bus.adc_sck) begin
        if (bus.adc_convst === 1'b1) begin
            convst_cnt++;
            if (sdi_bits == 6) cfg_cur = cfg_in;
            sdi_bits  = 0;
            frame_sck = 0;
            shreg = adc_val({cfg_cur[3], cfg_cur[2], cfg_cur[4]});
        end else if (bus.adc_sck === 1'b1) begin
            frame_sck++;
            if (sdi_bits < 6) begin
                cfg_in = {cfg_in[4:0], bus.adc_sdi};
                sdi_bits++;
                if (sdi_bits == 6) last_cfg = cfg_in;
            end
        end else begin
            shreg = {shreg[10:0], 1'b0};
        end
    end
    assign bus.adc_sdo = shreg[11];

    // ---------------- stream monitor ----------------
    logic [34:0] act_q [$];
    always @(negedge clk)
        if (bus.data_stream_valid_adc === 1'b1)
            act_q.push_back({bus.data_stream_ch, bus.data_stream_adc});

    // ---------------- expectation model ----------------
    logic [34:0] exp_q [$];
    int          act_rd = 0;
    bit          m_primed = 0;
    logic [2:0]  m_last = '0;
    int          c0 = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One tick: the channel list, minus its head when the ADC was not
    // already configured for that head.
    task automatic model_tick();
        int l [$];
        if (!scan_mode) l.push_back(int'(sel_ch));
        else for (int i = 0; i < 8; i++) if (ch_mask[i]) l.push_back(i);
        if (l.size() == 0) return;
        for (int i = 0; i < l.size(); i++)
            if (i > 0 || (m_primed && int'(m_last) == l[0]))
                exp_q.push_back({3'(l[i]), 20'b0, adc_val(3'(l[i]))});
        m_last   = 3'(l[0]);
        m_primed = 1;
    endtask

    task automatic check_outputs(input string tag);
        int n_act = act_q.size() - act_rd;
        chk({tag, "_count"}, 64'(n_act), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n_act; i++)
            chk({tag, "_word"}, 64'(act_q[act_rd + i]), 64'(exp_q[i]));
        act_rd = act_q.size();
        exp_q.delete();
    endtask

    task automatic flush();
        act_rd = act_q.size();
        exp_q.delete();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic enable_on();
        @(negedge clk);
        enable   = 1'b1;
        c0       = cyc;
        m_primed = 0;
    endtask

    task automatic enable_off();
        @(negedge clk);
        enable   = 1'b0;
        m_primed = 0;
    endtask

    // Advance n timer ticks and let the last scan finish.
    task automatic step(input int n);
        int p = int'(periodo_muestreo);
        int k = (cyc - c0) / p + 1;
        for (int i = 0; i < n; i++) model_tick();
        while (cyc < c0 + (k + n - 1) * p + MARGIN) @(negedge clk);
    endtask

    task automatic wait_convst(input int target, input string tag);
        int n = 0;
        while (convst_cnt < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(convst_cnt >= target), 64'd1);
    endtask

    initial begin
        int base;
        for (int i = 0; i < 8; i++) rand_tab[i] = 12'($urandom);

        // Reset state
        wait_cycles(3);
        chk("rst_convst", 64'(bus.adc_convst), 64'd0);
        chk("rst_sck",    64'(bus.adc_sck), 64'd0);
        chk("rst_sdi",    64'(bus.adc_sdi), 64'd0);
        chk("rst_data",   64'(bus.data_stream_adc), 64'd0);
        chk("rst_ch",     64'(bus.data_stream_ch), 64'd0);
        chk("rst_valid",  64'(bus.data_stream_valid_adc), 64'd0);
        chk("rst_ovr",    64'(overrun), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single channel 5
        value_mode = 0;
        periodo_muestreo = 32'd2000;
        scan_mode = 1'b0;
        sel_ch = 3'd5;
        enable_on();
        step(1);
        chk("single_cfg", 64'(last_cfg), 64'(6'b111010));
        check_outputs("single_prime");
        step(1);
        check_outputs("single_steady");
        chk("single_hold_data", 64'(bus.data_stream_adc), 64'h0000_0A5C);
        chk("single_hold_ch",   64'(bus.data_stream_ch), 64'd5);

        // Scan 0,2,5 (first scan re-primes from channel 5)
        value_mode = 1;
        scan_mode = 1'b1;
        ch_mask = 8'b0010_0101;
        step(1);
        check_outputs("scan_reprime");
        step(2);
        check_outputs("scan_steady");

        // Randomised selections
        value_mode = 2;
        for (int r = 0; r < 5; r++) begin
            scan_mode = 1'($urandom_range(0, 1));
            sel_ch    = 3'($urandom_range(0, 7));
            ch_mask   = 8'($urandom);
            if (r == 3) begin
                scan_mode = 1'b1;
                ch_mask   = 8'd0;
            end
            step(2);
            check_outputs("rand");
        end

        // Empty mask: ticks ignored
        enable_off();
        periodo_muestreo = 32'd200;
        scan_mode = 1'b1;
        ch_mask = 8'd0;
        base = convst_cnt;
        enable_on();
        wait_cycles(10 * 200 + 20);
        chk("mask0_convst", 64'(convst_cnt), 64'(base));
        check_outputs("mask0");
        chk("mask0_ovr", 64'(overrun), 64'd0);

        // Overrun
        enable_off();
        periodo_muestreo = 32'd100;
        ch_mask = 8'b0010_0101;
        value_mode = 1;
        enable_on();
        wait_cycles(1000);
        chk("ovr_set", 64'(overrun), 64'd1);
        wait_cycles(500);
        chk("ovr_sticky", 64'(overrun), 64'd1);
        enable_off();
        wait_cycles(2);
        chk("ovr_clear", 64'(overrun), 64'd0);
        wait_cycles(600);
        flush();

        // Enable dropped during SHIFT of the second frame
        periodo_muestreo = 32'd2000;
        base = convst_cnt;
        enable_on();
        wait_convst(base + 2, "abort_reach");
        wait_cycles(90);
        enable_off();
        wait_cycles(200);
        chk("abort_sck", 64'(frame_sck), 64'd12);
        chk("abort_idle", 64'(convst_cnt), 64'(base + 2));
        check_outputs("abort_novalid");
        enable_on();
        step(1);
        check_outputs("abort_reprime");

        // Reset during CONV
        enable_off();
        periodo_muestreo = 32'd100;
        scan_mode = 1'b0;
        sel_ch = 3'd3;
        value_mode = 2;
        enable_on();
        wait_cycles(300);
        chk("rst_pre_ovr", 64'(overrun), 64'd1);
        wait_convst(convst_cnt + 1, "rst_reach");
        wait_cycles(5);
        #2 reset = 1'b1;
        #1;
        chk("arst_convst", 64'(bus.adc_convst), 64'd0);
        chk("arst_sck",    64'(bus.adc_sck), 64'd0);
        chk("arst_valid",  64'(bus.data_stream_valid_adc), 64'd0);
        chk("arst_ovr",    64'(overrun), 64'd0);
        chk("arst_data",   64'(bus.data_stream_adc), 64'd0);
        periodo_muestreo = 32'd2000;
        wait_cycles(3);
        reset = 1'b0;
        c0 = cyc;
        m_primed = 0;
        flush();
        step(2);
        check_outputs("rst_reprime");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
